// File: rtl/serial_subtractor.sv
// Purpose: bit-serial subtractor, diff = a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: start accepted at edge k -> done high for one cycle after edge k+WIDTH; one op per WIDTH+1 cycles.
// Backpressure: start is only sampled while busy=0 (IDLE or DONE); a start during an operation is ignored.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset, clears all state and outputs
//   start          request; a and b are captured on the accepting edge
//   a, b           minuend / subtrahend (WIDTH bits, unsigned)
//   busy           operation in progress
//   done           one-cycle pulse, diff/borrow valid
//   diff, borrow   a - b mod 2^WIDTH and unsigned borrow (a < b); held until next accept
//   ovf            two's-complement overflow flag, only when SIGNED_OVF_EN is defined
//
// Optional feature macro: SIGNED_OVF_EN (adds the ovf port and its sign-bit capture).

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;

    logic             d;
    logic             br_nxt;
    logic             last;
    logic [WIDTH-1:0] diff_shift;

`ifdef SIGNED_OVF_EN
    // Operand sign bits kept from the accept edge; the shift regs lose them.
    logic a_msb;
    logic b_msb;
`endif

    // Full-subtractor cell on the current operand LSBs.
    assign d      = sa[0] ^ sb[0] ^ br;
    assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands at diff[0].
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_shift = d;
        end else begin : g_wn
            assign diff_shift = {d, diff[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        sa     <= a;
                        sb     <= b;
                        br     <= 1'b0;
                        cnt    <= '0;
                        diff   <= '0;
                        borrow <= 1'b0;
`ifdef SIGNED_OVF_EN
                        ovf    <= 1'b0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    diff <= diff_shift;
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        borrow <= br_nxt;
`ifdef SIGNED_OVF_EN
                        // d is the result MSB being shifted in this cycle.
                        ovf    <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
